pipeline_ctrl: RTL



---
 rtl/pipeline_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, jump, mult/div,
// external-wait and exception sources into per-stage enables, flushes and PC control.
module pipeline_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hazard_stall,
    input  logic       ID_jumpTaken,
    input  logic       EX_mdStart,
    input  logic       EX_mdIsDiv,
    input  logic       ext_stall,
    input  logic       MEM_exception,
    output logic       PC_en,
    output logic       IF_ID_en,
    output logic       ID_EX_en,
    output logic       EX_MEM_en,
    output logic       MEM_WB_en,
    output logic       IF_ID_flush,
    output logic       ID_EX_flush,
    output logic       EX_MEM_flush,
    output logic       MEM_WB_flush,
    output logic       pc_sel_exc,
    output logic       md_busy,
    output logic       md_done,
    output logic [1:0] ctrl_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MDWAIT = 2'd1,
        EXC    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign ctrl_state = state;

    // Sources are evaluated strictly in priority order; the first match owns the cycle.
    always_comb begin
        PC_en        = 1'b1;
        IF_ID_en     = 1'b1;
        ID_EX_en     = 1'b1;
        EX_MEM_en    = 1'b1;
        MEM_WB_en    = 1'b1;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        MEM_WB_flush = 1'b0;
        pc_sel_exc   = 1'b0;
        md_done      = 1'b0;
        state_next   = state;
        cnt_next     = cnt;

        if (MEM_exception) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
            MEM_WB_flush = 1'b1;
            pc_sel_exc   = 1'b1;
            cnt_next     = '0;
            state_next   = EXC;
        end else if (ext_stall) begin
            PC_en     = 1'b0;
            IF_ID_en  = 1'b0;
            ID_EX_en  = 1'b0;
            EX_MEM_en = 1'b0;
            MEM_WB_en = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (EX_mdStart) begin
                        PC_en        = 1'b0;
                        IF_ID_en     = 1'b0;
                        ID_EX_en     = 1'b0;
                        EX_MEM_flush = 1'b1;
                        cnt_next     = EX_mdIsDiv ? DIV_LOAD : MUL_LOAD;
                        state_next   = MDWAIT;
                    end else if (hazard_stall) begin
                        PC_en       = 1'b0;
                        IF_ID_en    = 1'b0;
                        ID_EX_flush = 1'b1;
                    end else if (ID_jumpTaken) begin
                        IF_ID_flush = 1'b1;
                    end
                end
                MDWAIT: begin
                    // EX stays occupied until the counter drains; a bubble feeds MEM meanwhile.
                    if (cnt != '0) begin
                        PC_en        = 1'b0;
                        IF_ID_en     = 1'b0;
                        ID_EX_en     = 1'b0;
                        EX_MEM_flush = 1'b1;
                        cnt_next     = cnt - CNT_W'(1);
                    end else begin
                        md_done    = rst_n;
                        state_next = RUN;
                    end
                end
                EXC: begin
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RUN;
            cnt     <= '0;
            md_busy <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            md_busy <= (state_next == MDWAIT);
        end
    end

endmodule
